// File: rtl/lsu_pkg.sv
// Shared funct3 encodings and lane helpers for the RV32I data-memory load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned LANES = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte enables for a store of the given width at the given word offset.
    function automatic logic [LANES-1:0] byte_en(input logic [2:0] funct3, input logic [1:0] offset);
        logic [LANES-1:0] be;
        be = 4'b1111;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << offset;
            2'b01:   be = 4'b0011 << offset;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Select the addressed lane of a read word and sign- or zero-extend it.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                    input logic [2:0]      funct3,
                                                    input logic [1:0]      offset);
        logic [7:0]      lane_b;
        logic [15:0]     lane_h;
        logic [XLEN-1:0] res;
        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    res = {{24{lane_b[7]}}, lane_b};
            F3_H:    res = {{16{lane_h[15]}}, lane_h};
            F3_W:    res = word;
            F3_BU:   res = {24'd0, lane_b};
            F3_HU:   res = {16'd0, lane_h};
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = offset[0];
            F3_W:        mis = (offset != 2'd0);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised data array with per-byte write enables and a registered read port.
module byte_lane_ram #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    i_re,
    input  logic [DATA_WIDTH/8-1:0] i_we,
    input  logic [ADDR_WIDTH-3:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 1 << (ADDR_WIDTH - 2);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Read returns the word as it was before any write on the same edge.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
        for (int i = 0; i < LANES; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_lsu.sv
// RV32I load/store unit in front of a byte-lane data array: handshake, legality,
// lane steering and a single-entry response register.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int unsigned LANES = DATA_WIDTH / 8;

    logic                  w_req_ready;
    logic                  w_accept;
    logic [1:0]            w_offset;
    logic [ADDR_WIDTH-3:0] w_index;
    logic                  w_legal_f3;
    logic                  w_err;
    logic [LANES-1:0]      w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_ram_q;

    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic                  r_load_ok;
    logic [2:0]            r_funct3;
    logic [1:0]            r_offset;

    assign w_req_ready = !r_resp_valid || resp_ready;
    assign w_accept    = req_valid && w_req_ready;
    assign w_offset    = req_addr[1:0];
    assign w_index     = req_addr[ADDR_WIDTH-1:2];

    always_comb begin
        w_legal_f3 = 1'b0;
        if (req_we) begin
            w_legal_f3 = req_funct3 inside {F3_B, F3_H, F3_W};
        end else begin
            w_legal_f3 = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end
    end

    assign w_err = !w_legal_f3 || is_misaligned(req_funct3, w_offset);

    // Narrow stores replicate their data so every enabled lane sees the right byte.
    always_comb begin
        w_wdata = req_wdata;
        w_be    = '0;
        case (req_funct3[1:0])
            2'b00:   w_wdata = {(DATA_WIDTH/8){req_wdata[7:0]}};
            2'b01:   w_wdata = {(DATA_WIDTH/16){req_wdata[15:0]}};
            default: w_wdata = req_wdata;
        endcase
        if (w_accept && req_we && !w_err && !rst) begin
            w_be = byte_en(req_funct3, w_offset);
        end
    end

    byte_lane_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_re    (w_accept),
        .i_we    (w_be),
        .i_addr  (w_index),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_q)
    );

    // Response register: loads on accept, clears once consumed with nothing new behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_load_ok    <= 1'b0;
            r_funct3     <= 3'd0;
            r_offset     <= 2'd0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_load_ok    <= !req_we && !w_err;
            r_funct3     <= req_funct3;
            r_offset     <= w_offset;
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign req_ready  = w_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_valid && r_resp_err;
    assign resp_rdata = (r_resp_valid && r_load_ok) ? load_extend(w_ram_q, r_funct3, r_offset) : '0;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: byte-array reference model, directed and random traffic.
module tb_data_mem_lsu;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    int         errors = 0;
    int         checks = 0;
    int         ready_mode = 0;

    data_mem_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: RV32I semantics on a byte array, little-endian.
    function automatic exp_t model(input logic we, input logic [2:0] f3, input int a, input logic [31:0] wd);
        exp_t        e;
        int          size;
        logic        legal;
        logic [31:0] v;
        size  = 1 << f3[1:0];
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.rdata = 32'd0;
        e.err   = 1'b0;
        if (!legal || (a % size) != 0) begin
            e.err = 1'b1;
            return e;
        end
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[a+i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[a+i];
            if (!f3[2] && size < 4 && v[8*size-1]) begin
                for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            e.rdata = v;
        end
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [AW-1:0] a, input logic [31:0] wd);
        int n;
        n          = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        forever begin
            @(negedge clk);
            if (req_ready) begin
                sb_q.push_back(model(we, f3, int'(a), wd));
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Consumer readiness driver.
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = 1'($urandom_range(0, 1));
                default: resp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every presented response is compared to the queue head; popped when consumed.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    chk("resp_rdata", resp_rdata, sb_q[0].rdata);
                    chk("resp_err", 32'(resp_err), 32'(sb_q[0].err));
                    if (resp_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        #1;
        chk("reset_valid", 32'(resp_valid), 32'd0);
        chk("reset_rdata", resp_rdata, 32'd0);
        chk("reset_err", 32'(resp_err), 32'd0);
        idle(2);
        rst = 1'b0;

        for (int w = 0; w < 64; w++) issue(1'b1, 3'b010, AW'(w*4), $urandom);

        issue(1'b1, 3'b010, 12'h010, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 12'h010, 32'd0);
        issue(1'b1, 3'b010, 12'h010, 32'h11223344);
        issue(1'b1, 3'b000, 12'h013, 32'h000000A5);
        issue(1'b0, 3'b000, 12'h013, 32'd0);
        issue(1'b0, 3'b100, 12'h013, 32'd0);
        issue(1'b0, 3'b010, 12'h010, 32'd0);
        issue(1'b1, 3'b010, 12'h020, 32'h00000000);
        issue(1'b1, 3'b001, 12'h022, 32'h00008001);
        issue(1'b0, 3'b001, 12'h022, 32'd0);
        issue(1'b0, 3'b101, 12'h022, 32'd0);
        issue(1'b0, 3'b010, 12'h020, 32'd0);
        issue(1'b0, 3'b010, 12'h031, 32'd0);
        issue(1'b0, 3'b001, 12'h033, 32'd0);
        issue(1'b1, 3'b010, 12'h032, 32'h12345678);
        issue(1'b1, 3'b011, 12'h030, 32'h87654321);
        issue(1'b0, 3'b010, 12'h030, 32'd0);
        issue(1'b0, 3'b101, 12'h011, 32'd0);

        // Back-pressure: first response held 5 cycles while a second request waits.
        idle(3);
        ready_mode = 2;
        idle(1);
        issue(1'b0, 3'b010, 12'h010, 32'd0);
        fork
            issue(1'b0, 3'b010, 12'h020, 32'd0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_req_ready", 32'(req_ready), 32'd0);
                    chk("bp_resp_valid", 32'(resp_valid), 32'd1);
                end
                ready_mode = 0;
            end
        join
        idle(3);
        chk("bp_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset with a held response and a store waiting.
        ready_mode = 2;
        idle(1);
        issue(1'b0, 3'b010, 12'h040, 32'd0);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 12'h040;
        req_wdata  = 32'hCAFEF00D;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(resp_valid), 32'd0);
        chk("arst_rdata", resp_rdata, 32'd0);
        chk("arst_err", 32'(resp_err), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        ready_mode = 0;
        idle(1);
        rst = 1'b0;
        issue(1'b0, 3'b010, 12'h040, 32'd0);
        issue(1'b0, 3'b010, 12'h010, 32'd0);
        issue(1'b0, 3'b010, 12'h020, 32'd0);

        // Random traffic with random consumer stalls.
        ready_mode = 1;
        for (int k = 0; k < 300; k++) begin
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), AW'($urandom_range(0, 255)), $urandom);
        end
        ready_mode = 0;

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Byte-addressed RV32I data memory with full load/store width support: LB/LH/LW/LBU/LHU and SB/SH/SW. Per-byte write enables and sign/zero extension on loads. Misaligned or illegal access detection.
Valid/ready request interface, a registered one-cycle response, and a single-entry response holding register for back-pressure. Sits between the core's MEM stage and the word-organised data array.

Parameters:
ADDR_WIDTH, 12, byte-address width; array holds 2**(ADDR_WIDTH-2) 32-bit words
DATA_WIDTH, 32, word width; fixed at 32 for RV32I, parameter exists for lane arithmetic (DATA_WIDTH/8 byte lanes)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept request this cycle
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 of the load/store
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data, right-aligned (rs2)
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal funct3

Behaviour:
- Reset (async, rst=1): resp_valid=0, resp_rdata=0, resp_err=0. Array contents are not reset and keep their values. A pending response is dropped. No write happens while rst=1.
- req_ready = !resp_valid || resp_ready. This is combinational and has no dependence on req_valid.
- Accept = req_valid && req_ready. On the accepting edge the response register loads and resp_valid=1 on the next cycle. Latency is 1 cycle.
- If a response is held and not accepted, the response and its outputs stay stable. If the response is accepted and no new request is accepted, resp_valid goes to 0 on the next edge.
- Word index = req_addr[ADDR_WIDTH-1:2]; offset = req_addr[1:0].
- Legal loads: funct3 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Anything else gives resp_err=1.
- Misalignment:
  - Halfword with offset[0]=1 is an error.
  - Word with offset!=0 is an error.
  - On error: no write, resp_rdata=0, resp_err=1.
- Store byte enables:
  - SB: 1 << offset.
  - SH: 4'b0011 << offset (offset is 0 or 2).
  - SW: 4'b1111.
  - Write data is replicated across lanes: SB = {4{wdata[7:0]}}, SH = {2{wdata[15:0]}}.
  - Only enabled bytes change. The write commits at the accepting edge.
- Loads: the array word is read synchronously at the accepting edge, then the lane is selected by offset.
  - LB/LH sign-extend bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
- Store responses: resp_rdata=0, resp_err=0 if legal.
- Store then load of the same word in back-to-back accepted cycles: the load returns the updated data. This requires no forwarding, because the write commits at the earlier edge.
- Address wrap: none. The address width exactly covers the array.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - Function byte_en(funct3, offset).
  - Function load_extend(word, funct3, offset).
  - Function is_misaligned(funct3, offset).
- Sub-module byte_lane_ram:
  - Word array with a DATA_WIDTH/8-bit write-enable vector and synchronous read.
  - Parameters ADDR_WIDTH and DATA_WIDTH.
  - No reset.
- The top level holds the handshake, legality checks, lane steering and the response register.

Test Plan:
- SW addr 0x010, wdata 0xDEADBEEF, then LW 0x010 back-to-back -> store resp err=0 rdata=0; load resp 0xDEADBEEF one cycle after accept.
- SB 0x013 wdata 0x000000A5 over word 0x11223344, then LB 0x013 / LBU 0x013 / LW 0x010 -> 0xFFFFFFA5 / 0x000000A5 / 0xA5223344.
- SH 0x022 wdata 0x00008001 over 0x00000000, then LH 0x022 / LHU 0x022 -> 0xFFFF8001 / 0x00008001; word reads 0x80010000.
- LW 0x031, LH 0x033, SW 0x032, store funct3=3'b011 -> each resp_err=1, rdata=0; LW 0x030 afterwards shows prior contents unchanged.
- Back-pressure: hold resp_ready=0 with req_valid=1 -> req_ready=0 and the first response stays stable for 5 cycles. Raise resp_ready -> the next request is accepted in the same cycle and its response follows one cycle later, none lost or duplicated.
- Assert rst asynchronously while resp_valid=1 and a store is presented -> resp_valid/rdata/err immediately 0, no write occurs; previously written words are still intact after reset.
